// File: rtl/soc_bus_pkg.sv
// rtl/soc_bus_pkg.sv - shared bus widths, memory latency and master indices
package soc_bus_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_RD_LAT = 1;

  localparam int IF     = 0;
  localparam int LSU    = 1;
  localparam int LOADER = 2;

  typedef enum logic [1:0] {
    M_IF     = 2'd0,
    M_LSU    = 2'd1,
    M_LOADER = 2'd2
  } master_e;

  // Increment with explicit wrap so non-power-of-two master counts work.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or after ptr
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!any && req[pos[PW-1:0]]) begin
        any              = 1'b1;
        gnt[pos[PW-1:0]] = 1'b1;
        idx              = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// rtl/soc_bus_arbiter.sv - round-robin, lockable arbiter in front of the single-port SoC memory
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int NUM_M  = 3,
  parameter int ADDR_W = soc_bus_pkg::ADDR_W,
  parameter int DATA_W = soc_bus_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M-1:0]         m_req,
  input  logic [NUM_M-1:0]         m_lock,
  input  logic [NUM_M-1:0]         m_we,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr,
  input  logic [NUM_M*DATA_W-1:0]  m_wdata,
  output logic [NUM_M-1:0]         m_gnt,
  output logic [NUM_M-1:0]         m_rvalid,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     s_en,
  output logic                     s_we,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic [DATA_W-1:0]        s_rdata
);

  localparam int PW = $clog2(NUM_M);

  logic [PW-1:0]    ptr;
  logic             own_v;
  logic [PW-1:0]    own_id;
  logic             rsp_v;
  logic [PW-1:0]    rsp_id;

  logic [NUM_M-1:0] req_eff;
  logic [NUM_M-1:0] pick;
  logic [PW-1:0]    win;
  logic             any;
  logic             acc;

  // While locked only the owner is visible; ptr sits at owner+1 so the picker still finds it.
  always_comb begin
    req_eff = m_req;
    if (own_v) req_eff = m_req & (NUM_M'(1) << own_id);
  end

  rr_pick #(.N(NUM_M), .PW(PW)) u_pick (
    .req (req_eff),
    .ptr (ptr),
    .gnt (pick),
    .idx (win),
    .any (any)
  );

  assign acc   = any & ~rst;
  assign m_gnt = acc ? pick : '0;

  always_comb begin
    s_en    = acc;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (acc) begin
      s_we    = m_we[win];
      s_addr  = m_addr[int'(win)*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[int'(win)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      own_v  <= 1'b0;
      own_id <= '0;
      rsp_v  <= 1'b0;
      rsp_id <= '0;
    end else begin
      rsp_v  <= acc & ~m_we[win];
      rsp_id <= win;
      if (acc) begin
        ptr    <= PW'(wrap_inc(int'(win), NUM_M));
        own_v  <= m_lock[win];
        own_id <= win;
      end
    end
  end

  assign m_rvalid = rsp_v ? (NUM_M'(1) << rsp_id) : '0;
  assign m_rdata  = rsp_v ? s_rdata : '0;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// tb/tb_soc_bus_arbiter.sv - directed bench for soc_bus_arbiter with read-response scoreboard
module tb_soc_bus_arbiter;

  localparam int NUM_M  = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                    clk;
  logic                    rst;
  logic [NUM_M-1:0]        m_req;
  logic [NUM_M-1:0]        m_lock;
  logic [NUM_M-1:0]        m_we;
  logic [NUM_M*ADDR_W-1:0] m_addr;
  logic [NUM_M*DATA_W-1:0] m_wdata;
  logic [NUM_M-1:0]        m_gnt;
  logic [NUM_M-1:0]        m_rvalid;
  logic [DATA_W-1:0]       m_rdata;
  logic                    s_en;
  logic                    s_we;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [DATA_W-1:0]       s_rdata;

  soc_bus_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_lock   (m_lock),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .s_en     (s_en),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
  endfunction

  // Single-port memory with 1-cycle read latency, loaded once at the first reset.
  logic [31:0] mem [0:255];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (rst && !loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (s_en) begin
      if (s_we) mem[s_addr[7:0]] <= s_wdata;
      else      s_rdata <= mem[s_addr[7:0]];
    end
  end

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] exp_mem [0:255];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: settle, check response/grant/memory port, then move to the next falling edge.
  task automatic tick(input logic [NUM_M-1:0] eg, input string tag, input bit rst_after = 1'b0);
    rsp_t        e;
    int          w;
    logic [31:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " rvalid"}, 64'(m_rvalid), 64'(1) << e.id);
      chk({tag, " rdata"}, 64'(m_rdata), 64'(e.data));
    end else begin
      chk({tag, " rvalid_idle"}, 64'(m_rvalid), 64'(0));
      if (rst) chk({tag, " rdata_rst"}, 64'(m_rdata), 64'(0));
    end
    chk({tag, " gnt"}, 64'(m_gnt), 64'(eg));
    if (eg != '0) begin
      w = 0;
      for (int i = 0; i < NUM_M; i++) if (eg[i]) w = i;
      a = m_addr[w*ADDR_W +: ADDR_W];
      chk({tag, " s_en"}, 64'(s_en), 64'(1));
      chk({tag, " s_addr"}, 64'(s_addr), 64'(a));
      chk({tag, " s_we"}, 64'(s_we), 64'(m_we[w]));
      if (m_we[w]) begin
        chk({tag, " s_wdata"}, 64'(s_wdata), 64'(m_wdata[w*DATA_W +: DATA_W]));
        exp_mem[a[7:0]] = m_wdata[w*DATA_W +: DATA_W];
      end else if (!rst_after) begin
        e.id   = w;
        e.data = exp_mem[a[7:0]];
        exp_q.push_back(e);
      end
    end else begin
      chk({tag, " s_en_idle"}, 64'(s_en), 64'(0));
      chk({tag, " s_addr_idle"}, 64'(s_addr), 64'(0));
    end
    if (rst_after) rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    rst     = 1'b1;
    m_req   = 3'b111;
    m_lock  = '0;
    m_we    = '0;
    m_wdata = '0;
    m_addr  = {32'h28, 32'h24, 32'h20};
    @(negedge clk);
    tick(3'b000, "rst0");
    tick(3'b000, "rst1");

    rst = 1'b0;
    tick(3'b001, "rr0");
    tick(3'b010, "rr1");
    tick(3'b100, "rr2");
    tick(3'b001, "rr3");

    m_req = 3'b010;
    m_addr[32 +: 32] = 32'h10;
    tick(3'b010, "rd10");
    m_req = 3'b000;
    tick(3'b000, "rd10_rsp");

    m_req = 3'b101;
    m_we  = 3'b100;
    m_lock = 3'b100;
    m_addr[64 +: 32]  = 32'h0;
    m_wdata[64 +: 32] = 32'h0000_0013;
    m_addr[0 +: 32]   = 32'h0;
    repeat (4) tick(3'b100, "lock");
    m_lock = 3'b000;
    tick(3'b100, "lock_rel");
    tick(3'b001, "after_rel");
    m_req = 3'b000;
    m_we  = 3'b000;
    tick(3'b000, "rd13_rsp");

    m_req  = 3'b001;
    m_lock = 3'b001;
    m_addr[0 +: 32] = 32'h10;
    tick(3'b001, "own");
    m_req = 3'b010;
    repeat (3) tick(3'b000, "own_drop");
    m_req  = 3'b011;
    m_lock = 3'b000;
    tick(3'b001, "own_rel");
    m_req = 3'b010;
    tick(3'b010, "m1_after");

    m_req = 3'b010;
    tick(3'b010, "squash", 1'b1);
    rst   = 1'b0;
    m_req = 3'b111;
    tick(3'b001, "squash_after");

    m_req = 3'b100;
    repeat (4) tick(3'b100, "only2");
    m_req = 3'b111;
    tick(3'b001, "all0");
    tick(3'b010, "all1");
    tick(3'b100, "all2");
    m_req = 3'b000;
    tick(3'b000, "idle");
    tick(3'b000, "idle2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
